// File: rtl/regfile_mp_pkg.sv
// Shared defaults and constants for the multi-ported register file.
// Holds widths, the zero word/address, write-enable polarity and the address-validity helper.
package regfile_mp_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;
    localparam int ZERO_ADDR = 0;
    localparam logic WE_ACTIVE = 1'b1;

    // Register 0 is hardwired and addresses past the implemented range are dead.
    function automatic logic addr_ok(input int addr, input int num_regs);
        return (addr != ZERO_ADDR) && (addr < num_regs);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: claim sets, writeback clears, flush wipes everything.
// Outputs the stored busy bit for each read port address.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = 32,
    parameter int RD_PORTS = 2,
    parameter int WR_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WR_PORTS-1:0]          wr_ok,
    input  logic [WR_PORTS*ADDR_W-1:0]   wr_addr,
    input  logic                         claim_en,
    input  logic [ADDR_W-1:0]            claim_addr,
    input  logic                         flush,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [RD_PORTS-1:0]          rd_stored_busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                claim_ok;

    assign claim_ok = claim_en && addr_ok(32'(claim_addr), NUM_REGS);

    // The claim is applied after the clears so a same-cycle claim stays the newest producer.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                for (int p = 0; p < WR_PORTS; p++) begin
                    if (wr_ok[p] && (wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(i))) begin
                        busy_d[i] = 1'b0;
                    end
                end
                if (claim_ok && (claim_addr == ADDR_W'(i))) begin
                    busy_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_stored_busy = '0;
        for (int r = 0; r < RD_PORTS; r++) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (rd_addr[r*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
                    rd_stored_busy[r] = busy_q[i];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported integer register file with busy scoreboard for the decode/writeback boundary.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy-clear to the read ports.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = 32,
    parameter int RD_PORTS = 2,
    parameter int WR_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WR_PORTS-1:0]          wr_en,
    input  logic [WR_PORTS*ADDR_W-1:0]   wr_addr,
    input  logic [WR_PORTS*DATA_W-1:0]   wr_data,
    input  logic [RD_PORTS-1:0]          rd_en,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data,
    output logic [RD_PORTS-1:0]          rd_busy,
    input  logic                         claim_en,
    input  logic [ADDR_W-1:0]            claim_addr,
    input  logic                         flush
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [WR_PORTS-1:0] wr_ok;
    logic [RD_PORTS-1:0] sb_busy;

    always_comb begin
        wr_ok = '0;
        for (int p = 0; p < WR_PORTS; p++) begin
            wr_ok[p] = (wr_en[p] == WE_ACTIVE) &&
                       addr_ok(32'(wr_addr[p*ADDR_W +: ADDR_W]), NUM_REGS);
        end
    end

    // Later ports overwrite earlier ones, so the highest-index port wins a conflict.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            for (int p = 0; p < WR_PORTS; p++) begin
                if (wr_ok[p] && (wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(i))) begin
                    regs_d[i] = wr_data[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= DATA_W'(ZERO_WORD);
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .RD_PORTS (RD_PORTS),
        .WR_PORTS (WR_PORTS)
    ) u_scoreboard (
        .clk            (clk),
        .rst            (rst),
        .wr_ok          (wr_ok),
        .wr_addr        (wr_addr),
        .claim_en       (claim_en),
        .claim_addr     (claim_addr),
        .flush          (flush),
        .rd_addr        (rd_addr),
        .rd_stored_busy (sb_busy)
    );

    // Register 0 and out-of-range addresses never match the mux, so they read as zero.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int r = 0; r < RD_PORTS; r++) begin
            if (rd_en[r] && !flush && !rst) begin
                for (int i = 1; i < NUM_REGS; i++) begin
                    if (rd_addr[r*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
                        rd_data[r*DATA_W +: DATA_W] = regs_q[i];
                    end
                end
                rd_busy[r] = sb_busy[r];
`ifdef REGFILE_BYPASS_EN
                for (int p = 0; p < WR_PORTS; p++) begin
                    if (wr_ok[p] && (wr_addr[p*ADDR_W +: ADDR_W] == rd_addr[r*ADDR_W +: ADDR_W])) begin
                        rd_data[r*DATA_W +: DATA_W] = wr_data[p*DATA_W +: DATA_W];
                        rd_busy[r] = 1'b0;
                    end
                end
`endif
            end
        end
    end

endmodule
